// File: rtl/cnn_pkg.sv
// Shared types and defaults for the ReLU + 2x2 max-pool stage behind the conv core.
package cnn_pkg;

  localparam int O_F_BW_DEF = 23;
  localparam int CO_DEF     = 3;
  localparam int IW_DEF     = 24;
  localparam int IH_DEF     = 24;

  typedef logic signed [O_F_BW_DEF-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cnn_pool_lbuf.sv
// Half-row buffer: holds the horizontal pair maxima of an even row until the odd row reads them.
module cnn_pool_lbuf #(
  parameter int DEPTH = 12,
  parameter int W     = 69,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cnn_relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster stream, CO channels in parallel.
// Build option: define CNN_POOL_RELU_EN to enable ReLU; otherwise pooling uses raw signed inputs.
module cnn_relu_maxpool
  import cnn_pkg::*;
#(
  parameter int O_F_BW = O_F_BW_DEF,
  parameter int CO     = CO_DEF,
  parameter int IW     = IW_DEF,
  parameter int IH     = IH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_valid,
  input  logic [CO*O_F_BW-1:0] i_data,
  output logic                 o_valid,
  output logic [CO*O_F_BW-1:0] o_data,
  output logic                 o_done
);

  localparam int OW = IW / 2;
  localparam int OH = IH / 2;
  localparam int CW = $clog2(IW);
  localparam int RW = $clog2(IH);
  localparam int AW = CW - 1;
  localparam int NW = $clog2(OW * OH);
  localparam logic [CW-1:0] COL_LAST = CW'(IW - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IH - 1);
  localparam logic [NW-1:0] CNT_LAST = NW'(OW * OH - 1);

  if ((IW % 2) != 0 || (IH % 2) != 0) begin : g_bad_dims
    $error("cnn_relu_maxpool: IW and IH must be even");
  end
  if (O_F_BW != O_F_BW_DEF) begin : g_bad_width
    $error("cnn_relu_maxpool: O_F_BW must match cnn_pkg sample width");
  end

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [NW-1:0] ocnt_q, ocnt_d;
  logic          pool_fire;
  logic          o_valid_q, o_done_q;
  logic [CO*O_F_BW-1:0] o_data_q;
  logic [CO*O_F_BW-1:0] lb_rd, lb_wr, pool_d;

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    ocnt_d    = ocnt_q;
    pool_fire = i_valid & col_q[0] & row_q[0];
    if (i_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (pool_fire) ocnt_d = (ocnt_q == CNT_LAST) ? '0 : ocnt_q + 1'b1;
  end

  for (genvar c = 0; c < CO; c++) begin : g_ch
    sample_t x, rx, hmax, lb;
    sample_t h_q;

    assign x = i_data[c*O_F_BW +: O_F_BW];
`ifdef CNN_POOL_RELU_EN
    assign rx = x[O_F_BW-1] ? '0 : x;
`else
    assign rx = x;
`endif
    assign hmax = smax(h_q, rx);
    assign lb   = lb_rd[c*O_F_BW +: O_F_BW];
    assign lb_wr[c*O_F_BW +: O_F_BW]  = hmax;
    assign pool_d[c*O_F_BW +: O_F_BW] = smax(lb, hmax);

    // Left pixel of each horizontal pair; a reset cycle drops the sample.
    always_ff @(posedge clk) begin
      if (!reset_n && i_valid && !col_q[0]) h_q <= rx;
    end
  end

  cnn_pool_lbuf #(
    .DEPTH (OW),
    .W     (CO * O_F_BW),
    .AW    (AW)
  ) u_lbuf (
    .clk     (clk),
    .we_i    (!reset_n && i_valid && col_q[0] && !row_q[0]),
    .waddr_i (col_q[CW-1:1]),
    .wdata_i (lb_wr),
    .raddr_i (col_q[CW-1:1]),
    .rdata_o (lb_rd)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      col_q     <= '0;
      row_q     <= '0;
      ocnt_q    <= '0;
      o_valid_q <= 1'b0;
      o_done_q  <= 1'b0;
      o_data_q  <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      ocnt_q    <= ocnt_d;
      o_valid_q <= pool_fire;
      o_done_q  <= pool_fire && (ocnt_q == CNT_LAST);
      if (pool_fire) o_data_q <= pool_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_done  = o_done_q;
  assign o_data  = o_data_q;

endmodule

// File: doc/cnn_relu_maxpool.md
Name: cnn_relu_maxpool

Overview:
- Stage directly downstream of the 5x5 convolution core (cnn_top).
- Consumes the raster-order stream of CO-channel convolution results (24x24 per channel for a 28x28 image).
- Applies ReLU, then 2x2 stride-2 max pooling per channel, producing a 12x12xCO stream for the next layer.
- Streaming only; no backpressure; one input accepted per cycle when i_valid=1.

Parameters:
- O_F_BW, 23: signed two's-complement width of each convolution output channel sample.
- CO, 3: number of channels, processed in parallel.
- IW, 24: input feature-map width; must be even (elaboration-time check).
- IH, 24: input feature-map height; must be even (elaboration-time check).
- OW, IW/2: output width (derived).
- OH, IH/2: output height (derived).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-high reset (1 = reset), sampled on the rising edge of clk.
- i_valid  in  1  input sample valid.
- i_data  in  CO*O_F_BW  channel c at [c*O_F_BW +: O_F_BW], signed.
- o_valid  out  1  pooled sample valid, one-cycle pulse per output.
- o_data  out  CO*O_F_BW  pooled result, same packing as i_data.
- o_done  out  1  one-cycle pulse coincident with the final (OW*OH-th) o_valid of a frame.

Behaviour:
- Reset: o_valid=0, o_data=0, o_done=0, and col/row counters=0. Pooling line-buffer contents are not cleared (every even row overwrites them before they are read).
- ReLU per channel: x<0 -> 0, else x; applied before pooling.
- Counters:
  - col advances 0..IW-1 only on i_valid=1.
  - At col=IW-1, col wraps to 0 and row increments.
  - At row=IH-1, col=IW-1, both counters wrap to 0, so the next frame begins immediately.
- Even col: h_reg[c] <= relu(x).
- Odd col: hmax = max(h_reg, relu(x)), signed compare.
  - Even row: lbuf[col/2] <= hmax.
  - Odd row: o_data <= max(lbuf[col/2], hmax), with o_valid=1 on the next cycle.
- Latency: exactly 1 cycle from the accepting edge of pixel (odd row, odd col) to o_valid.
- i_valid gaps of any length are allowed: state holds and output values are unaffected. o_valid=0 except the cycle after a qualifying input.
- Output count: o_cnt counts emitted outputs 0..OW*OH-1. o_done=1 together with o_valid when o_cnt=OW*OH-1, then o_cnt wraps.
- o_data holds its last value when o_valid=0.
- Reset mid-frame: counters return to 0. The next i_valid is treated as pixel (0,0) of a new frame, and any partial pooled window is discarded.
- Reset dominates i_valid in the same cycle: that sample is dropped.
- Storage: lbuf is OW entries x CO*O_F_BW (register array); h_reg is CO*O_F_BW.

Optional Feature:
- Macro: CNN_POOL_RELU_EN.
- Defined: ReLU is applied as above, so outputs are always >= 0.
- Undefined: ReLU is bypassed and pooling is a pure signed max over raw inputs, so negative outputs are possible. Latency and timing are identical in both builds.

Decomposition:
- Shared package cnn_pkg holds:
  - O_F_BW, CO, IW, IH defaults;
  - a typedef for the signed sample, logic signed [O_F_BW-1:0];
  - a function smax(a,b) for the signed maximum.
- One natural sub-module: cnn_pool_lbuf, the OW-deep half-row buffer with a write port and a read port addressed by col/2.
- Channel datapath is generate-replicated CO times.

Test Plan:
- Ramp: every channel = linear index 0..575, continuous valid.
  - Expect 144 o_valid pulses.
  - Output (r,c) = (2r+1)*24+2c+1: first = 25, (0,1) = 27, last = 575.
  - o_done is coincident with the last output.
- Gapped valid: same ramp with i_valid toggling every other cycle -> identical 144 values; each o_valid arrives exactly 1 cycle after its odd/odd pixel.
- Negatives and channel independence: ch0 = idx, ch1 = -idx, ch2 = -5.
  - With CNN_POOL_RELU_EN: ch1 = 0, ch2 = 0.
  - Without: ch1 = -(2r*24+2c), ch2 = -5.
  - ch0 matches the ramp in both builds.
- Single peak: all zero except 1000 at pixel (row 5, col 7) -> output (2,3) = 1000, all other 143 outputs = 0.
- Reset mid-frame: assert reset_n=1 for 1 cycle after 300 ramp pixels, then send a full ramp frame -> exactly 144 outputs matching the ramp results and a single o_done.
- Back-to-back frames: two ramp frames with no gap -> 288 outputs, o_done pulses at outputs 144 and 288, and the second frame's first output = 25.
